alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: DATA_W, default 16, operand/result width; only 16 is supported, matching the alu datapath.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk_i  input  1  rising-edge clock.
REQ-004 rst_i  input  1  synchronous active-high reset.
REQ-005 req_valid_i  input  2  per-requester request valid; bit k is requester k.
REQ-006 req_ready_o  output  2  per-requester request accept.
REQ-007 req_func4_i  input  8  {func4 of requester 1, func4 of requester 0}.
REQ-008 req_rs1_i  input  32  {rs1 of requester 1, rs1 of requester 0}.
REQ-009 req_rs2_i  input  32  {rs2 of requester 1, rs2 of requester 0}.
REQ-010 req_imm_i  input  32  {imm of requester 1, imm of requester 0}.
REQ-011 req_imm_en_i  input  2  per-requester immediate select.
REQ-012 resp_valid_o  output  2  per-requester result valid.
REQ-013 resp_ready_i  input  2  per-requester result accept.
REQ-014 resp_data_o  output  16  result, shared by both requesters; meaningful only for the requester whose resp_valid_o bit is high.
REQ-015 resp_err_o  output  1  illegal-opcode flag, qualified by resp_valid_o.
REQ-016 busy_o  output  1  high when the FSM is not in IDLE.

Function
REQ-017 The block SHALL instantiate exactly one alu and share it between the two requesters.
REQ-018 The FSM SHALL have three states, IDLE, EXEC and RESP, and SHALL reset to IDLE.
REQ-019 In IDLE, req_ready_o SHALL be combinationally high for the granted requester only: at most one bit is high, and both bits are 0 when neither request is valid.
REQ-020 Grant: if exactly one req_valid_i bit is high, that requester wins; if both are high, the requester selected by the priority pointer prio wins.
REQ-021 On request handshake (valid && ready in IDLE):
- func4, rs1, rs2, imm, imm_en and the owner index are registered;
- the FSM goes to EXEC.
REQ-022 In EXEC:
- the alu is driven from the registered operands only;
- the alu output is registered into resp_data_o;
- the FSM goes to RESP unconditionally.
REQ-023 In RESP, resp_valid_o[owner] SHALL be 1 and the other bit SHALL be 0; resp_data_o and resp_err_o SHALL be held stable until the response handshake.
REQ-024 resp_ready_i of the non-owner SHALL be ignored.
REQ-025 On response handshake (resp_valid_o[owner] && resp_ready_i[owner]), the FSM SHALL go to IDLE and prio SHALL be set to the other requester. This applies even when the grant came from a single valid request.
REQ-026 Latency: a request accepted on edge N SHALL present its result at edge N+2 with resp_valid_o high. With resp_ready_i held high, the next request is accepted at edge N+3.
REQ-027 Illegal opcode (func4 > 4'b1000): resp_err_o SHALL be 1 and resp_data_o SHALL be 16'h0000, regardless of the alu output.
REQ-028 For legal opcodes, resp_err_o SHALL be 0.
REQ-029 Results SHALL be 16-bit and wrap modulo 2^16.
REQ-030 SLT is unsigned and yields 16'd0 or 16'd1.
REQ-031 When imm_en is set, imm replaces rs2.
REQ-032 Request inputs that change while not handshaken SHALL have no effect.
REQ-033 Operands SHALL NOT be resampled after acceptance.
REQ-034 A new request arriving during EXEC or RESP SHALL stall with req_ready_o = 0 until IDLE.
REQ-035 busy_o SHALL be 0 in IDLE and 1 in EXEC and RESP.

Reset
REQ-036 When rst_i is sampled high, the block SHALL go to IDLE on that edge with prio = 0 and all of the following cleared: resp_valid_o = 0, resp_data_o = 0, resp_err_o = 0, busy_o = 0, registered operands = 0.
REQ-037 Reset asserted in EXEC or RESP SHALL discard the in-flight operation, and no response SHALL be issued for it.
REQ-038 req_ready_o SHALL be 0 while rst_i is high.

Verification
REQ-039 Single request: requester 0 sends ADD (func4 0000), rs1 = 3, rs2 = 3, resp_ready_i = 11 -> resp_valid_o = 01 two edges after acceptance, resp_data_o = 6, resp_err_o = 0.
REQ-040 Contention: both requesters valid after reset, requester 0 sends SUB 10 - 3 and requester 1 sends XOR 12 ^ 10, resp_ready_i = 11 -> requester 0 is served first with result 7. Requester 1 is accepted 3 cycles later with result 6. Then requester 0 wins again on renewed contention.
REQ-041 Immediate: requester 1 sends ADD, rs1 = 10, rs2 = 999, imm = 7, imm_en = 1 -> resp_valid_o = 10, resp_data_o = 17.
REQ-042 Backpressure: requester 0 sends SLL 1 << 4 with resp_ready_i[0] = 0 for 5 cycles while requester 1 is valid -> resp_data_o is held at 16, req_ready_o stays 00 and busy_o stays 1. After resp_ready_i[0] rises, requester 1 is accepted in the next IDLE cycle.
REQ-043 Illegal opcode: func4 = 1111, rs1 = 5, rs2 = 5 -> resp_err_o = 1, resp_data_o = 0.
REQ-044 Reset mid-operation: rst_i is pulsed during EXEC of an AND request -> resp_valid_o never rises for that request, and the state is IDLE with prio = 0 on the next cycle.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_arbiter : two-requester front end sharing a single 16-bit alu
// Revision    : 1.0
// ---------------------------------------------------------------------------

module alu #(
   parameter int DATA_W = 16
) (
   input  logic [3:0]        func4_i,
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   output logic [DATA_W-1:0] res_o
);
   // 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (unsigned)
   always_comb begin
      res_o = '0;
      case (func4_i)
         4'h0:    res_o = a_i + b_i;
         4'h1:    res_o = a_i - b_i;
         4'h2:    res_o = a_i & b_i;
         4'h3:    res_o = a_i | b_i;
         4'h4:    res_o = a_i ^ b_i;
         4'h5:    res_o = a_i << b_i[3:0];
         4'h6:    res_o = a_i >> b_i[3:0];
         4'h7:    res_o = $unsigned($signed(a_i) >>> b_i[3:0]);
         4'h8:    res_o = {{(DATA_W-1){1'b0}}, (a_i < b_i)};
         default: res_o = '0;
      endcase
   end
endmodule

module alu_arbiter #(
   parameter int DATA_W = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          req_valid_i,
   output logic [1:0]          req_ready_o,
   input  logic [7:0]          req_func4_i,
   input  logic [2*DATA_W-1:0] req_rs1_i,
   input  logic [2*DATA_W-1:0] req_rs2_i,
   input  logic [2*DATA_W-1:0] req_imm_i,
   input  logic [1:0]          req_imm_en_i,
   output logic [1:0]          resp_valid_o,
   input  logic [1:0]          resp_ready_i,
   output logic [DATA_W-1:0]   resp_data_o,
   output logic                resp_err_o,
   output logic                busy_o
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                prio_q, prio_d;
   logic                owner_q, owner_d;
   logic [3:0]          func4_q, func4_d;
   logic [DATA_W-1:0]   rs1_q, rs1_d;
   logic [DATA_W-1:0]   rs2_q, rs2_d;
   logic [DATA_W-1:0]   imm_q, imm_d;
   logic                imm_en_q, imm_en_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                err_q, err_d;

   logic                gnt_idx;
   logic                accept;
   logic [DATA_W-1:0]   alu_b;
   logic [DATA_W-1:0]   alu_res;

   assign alu_b = imm_en_q ? imm_q : rs2_q;

   alu #(.DATA_W(DATA_W)) u_alu (
      .func4_i (func4_q),
      .a_i     (rs1_q),
      .b_i     (alu_b),
      .res_o   (alu_res)
   );

   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      owner_d     = owner_q;
      func4_d     = func4_q;
      rs1_d       = rs1_q;
      rs2_d       = rs2_q;
      imm_d       = imm_q;
      imm_en_d    = imm_en_q;
      data_d      = data_q;
      err_d       = err_q;
      req_ready_o = 2'b00;
      accept      = 1'b0;

      // Priority pointer only matters when both requesters contend.
      gnt_idx = (req_valid_i == 2'b11) ? prio_q : req_valid_i[1];

      case (state_q)
         IDLE: begin
            if (!rst_i && (req_valid_i != 2'b00)) begin
               req_ready_o = gnt_idx ? 2'b10 : 2'b01;
               accept      = 1'b1;
            end
            if (accept) begin
               owner_d  = gnt_idx;
               func4_d  = gnt_idx ? req_func4_i[7:4]            : req_func4_i[3:0];
               rs1_d    = gnt_idx ? req_rs1_i[2*DATA_W-1:DATA_W] : req_rs1_i[DATA_W-1:0];
               rs2_d    = gnt_idx ? req_rs2_i[2*DATA_W-1:DATA_W] : req_rs2_i[DATA_W-1:0];
               imm_d    = gnt_idx ? req_imm_i[2*DATA_W-1:DATA_W] : req_imm_i[DATA_W-1:0];
               imm_en_d = gnt_idx ? req_imm_en_i[1]             : req_imm_en_i[0];
               state_d  = EXEC;
            end
         end
         EXEC: begin
            err_d   = (func4_q > 4'b1000);
            data_d  = (func4_q > 4'b1000) ? '0 : alu_res;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready_i[owner_q]) begin
               prio_d  = ~owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         prio_q   <= 1'b0;
         owner_q  <= 1'b0;
         func4_q  <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         imm_q    <= '0;
         imm_en_q <= 1'b0;
         data_q   <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prio_q   <= prio_d;
         owner_q  <= owner_d;
         func4_q  <= func4_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         imm_q    <= imm_d;
         imm_en_q <= imm_en_d;
         data_q   <= data_d;
         err_q    <= err_d;
      end
   end

   assign resp_valid_o = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign resp_data_o  = data_q;
   assign resp_err_o   = err_q;
   assign busy_o       = (state_q != IDLE);
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_arbiter : directed self-checking bench for alu_arbiter
// Revision       : 1.0
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  req_valid_i;
   logic [1:0]  req_ready_o;
   logic [7:0]  req_func4_i;
   logic [31:0] req_rs1_i;
   logic [31:0] req_rs2_i;
   logic [31:0] req_imm_i;
   logic [1:0]  req_imm_en_i;
   logic [1:0]  resp_valid_o;
   logic [1:0]  resp_ready_i;
   logic [15:0] resp_data_o;
   logic        resp_err_o;
   logic        busy_o;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   alu_arbiter #(.DATA_W(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid_i),
      .req_ready_o  (req_ready_o),
      .req_func4_i  (req_func4_i),
      .req_rs1_i    (req_rs1_i),
      .req_rs2_i    (req_rs2_i),
      .req_imm_i    (req_imm_i),
      .req_imm_en_i (req_imm_en_i),
      .resp_valid_o (resp_valid_o),
      .resp_ready_i (resp_ready_i),
      .resp_data_o  (resp_data_o),
      .resp_err_o   (resp_err_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and land on the following falling edge.
   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic set_req(input int k, input logic [3:0] f, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] imm, input logic imm_en);
      req_func4_i[k*4 +: 4]   = f;
      req_rs1_i[k*16 +: 16]   = a;
      req_rs2_i[k*16 +: 16]   = b;
      req_imm_i[k*16 +: 16]   = imm;
      req_imm_en_i[k]         = imm_en;
      req_valid_i[k]          = 1'b1;
   endtask

   task automatic run_single(input string tag, input int k, input logic [3:0] f,
                             input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp_data, input logic exp_err);
      logic [1:0] onehot;
      onehot = (k == 1) ? 2'b10 : 2'b01;
      set_req(k, f, a, b, 16'h0, 1'b0);
      #1;
      check({tag, "_ready"}, req_ready_o, onehot);
      tick();
      req_valid_i[k] = 1'b0;
      tick();
      check({tag, "_valid"}, resp_valid_o, onehot);
      check({tag, "_data"},  resp_data_o, exp_data);
      check({tag, "_err"},   resp_err_o, exp_err);
      tick();
      check({tag, "_idle"},  busy_o, 1'b0);
   endtask

   initial begin
      rst_i        = 1'b1;
      req_valid_i  = 2'b00;
      req_func4_i  = '0;
      req_rs1_i    = '0;
      req_rs2_i    = '0;
      req_imm_i    = '0;
      req_imm_en_i = 2'b00;
      resp_ready_i = 2'b11;
      tick();
      tick();

      // Ready must stay low while reset is held, even with a valid request.
      req_valid_i = 2'b01;
      #1;
      check("rst_ready", req_ready_o, 2'b00);
      req_valid_i = 2'b00;
      rst_i = 1'b0;
      #1;
      check("rst_valid", resp_valid_o, 2'b00);
      check("rst_data",  resp_data_o, 16'h0);
      check("rst_err",   resp_err_o, 1'b0);
      check("rst_busy",  busy_o, 1'b0);

      // Single ADD request, checking the state at every cycle.
      set_req(0, 4'h0, 16'd3, 16'd3, 16'h0, 1'b0);
      #1;
      check("add_ready", req_ready_o, 2'b01);
      tick();
      req_valid_i = 2'b00;
      #1;
      check("add_exec_busy",  busy_o, 1'b1);
      check("add_exec_valid", resp_valid_o, 2'b00);
      tick();
      check("add_valid", resp_valid_o, 2'b01);
      check("add_data",  resp_data_o, 16'd6);
      check("add_err",   resp_err_o, 1'b0);
      tick();
      check("add_done_valid", resp_valid_o, 2'b00);
      check("add_done_busy",  busy_o, 1'b0);

      // Contention straight after reset: requester 0 first.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      set_req(0, 4'h1, 16'd10, 16'd3, 16'h0, 1'b0);
      set_req(1, 4'h4, 16'd12, 16'd10, 16'h0, 1'b0);
      #1;
      check("cont_ready0", req_ready_o, 2'b01);
      tick();
      req_valid_i[0] = 1'b0;
      tick();
      check("cont_sub_valid", resp_valid_o, 2'b01);
      check("cont_sub_data",  resp_data_o, 16'd7);
      check("cont_stall",     req_ready_o, 2'b00);
      set_req(0, 4'h2, 16'hF0F0, 16'h0FF0, 16'h0, 1'b0);
      tick();
      #1;
      check("cont_ready1", req_ready_o, 2'b10);
      tick();
      req_valid_i[1] = 1'b0;
      tick();
      check("cont_xor_valid", resp_valid_o, 2'b10);
      check("cont_xor_data",  resp_data_o, 16'd6);
      set_req(1, 4'h3, 16'd1, 16'd2, 16'h0, 1'b0);
      tick();
      #1;
      check("cont_ready0_again", req_ready_o, 2'b01);
      tick();
      req_valid_i = 2'b00;
      tick();
      check("cont_and_valid", resp_valid_o, 2'b01);
      check("cont_and_data",  resp_data_o, 16'h00F0);
      tick();

      // Immediate replaces rs2; operands changed after acceptance are ignored.
      set_req(1, 4'h0, 16'd10, 16'd999, 16'd7, 1'b1);
      #1;
      check("imm_ready", req_ready_o, 2'b10);
      tick();
      req_valid_i = 2'b00;
      req_rs1_i[31:16] = 16'd0;
      req_imm_i[31:16] = 16'd100;
      tick();
      check("imm_valid", resp_valid_o, 2'b10);
      check("imm_data",  resp_data_o, 16'd17);
      tick();

      // Backpressure on requester 0 while requester 1 waits.
      set_req(0, 4'h5, 16'd1, 16'd4, 16'h0, 1'b0);
      set_req(1, 4'h3, 16'd3, 16'd4, 16'h0, 1'b0);
      resp_ready_i = 2'b10;
      #1;
      check("bp_ready0", req_ready_o, 2'b01);
      tick();
      req_valid_i[0] = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_data",  resp_data_o, 16'd16);
         check("bp_hold_ready", req_ready_o, 2'b00);
         check("bp_hold_busy",  busy_o, 1'b1);
         check("bp_hold_valid", resp_valid_o, 2'b01);
         tick();
      end
      resp_ready_i = 2'b11;
      tick();
      #1;
      check("bp_ready1", req_ready_o, 2'b10);
      tick();
      req_valid_i = 2'b00;
      tick();
      check("bp_or_valid", resp_valid_o, 2'b10);
      check("bp_or_data",  resp_data_o, 16'd7);
      tick();

      // Boundary opcodes and wrap-around.
      run_single("illegal15", 0, 4'hF, 16'd5, 16'd5, 16'h0000, 1'b1);
      run_single("illegal9",  1, 4'h9, 16'd5, 16'd5, 16'h0000, 1'b1);
      run_single("slt_true",  0, 4'h8, 16'd3, 16'd5, 16'd1, 1'b0);
      run_single("slt_uns",   1, 4'h8, 16'hFFFF, 16'd1, 16'd0, 1'b0);
      run_single("add_wrap",  0, 4'h0, 16'hFFFF, 16'd2, 16'd1, 1'b0);
      run_single("sra",       1, 4'h7, 16'h8000, 16'd3, 16'hF000, 1'b0);
      run_single("srl",       0, 4'h6, 16'h8000, 16'd3, 16'h1000, 1'b0);

      // Reset during EXEC: pointer currently favours requester 1.
      set_req(0, 4'h2, 16'hFFFF, 16'h00FF, 16'h0, 1'b0);
      tick();
      req_valid_i = 2'b00;
      rst_i = 1'b1;
      #1;
      check("rstmid_exec_busy", busy_o, 1'b1);
      tick();
      rst_i = 1'b0;
      #1;
      check("rstmid_valid", resp_valid_o, 2'b00);
      check("rstmid_busy",  busy_o, 1'b0);
      check("rstmid_data",  resp_data_o, 16'h0);
      tick();
      check("rstmid_valid_later", resp_valid_o, 2'b00);
      set_req(0, 4'h0, 16'd1, 16'd1, 16'h0, 1'b0);
      set_req(1, 4'h0, 16'd2, 16'd2, 16'h0, 1'b0);
      #1;
      check("rstmid_prio0", req_ready_o, 2'b01);
      req_valid_i = 2'b00;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

`default_nettype wire
